// File: rtl/gemm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : gemm_pkg                                                   |
// | Description : Shared definitions for the GEMM tile scheduler and the     |
// |               systolic array datapath: 3-bit FSM state encodings and     |
// |               the counter/tile width helpers.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package gemm_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    LOAD  = S_LOAD,
    FEED  = S_FEED,
    DRAIN = S_DRAIN,
    DONE  = S_DONE
  } state_e;

  // Phase counter width: wide enough for the longest phase terminal index,
  // which is either the feed depth or the drain skew (2*N-1 cycles).
  function automatic int cnt_width(input int array_n, input int k_depth);
    int span;
    span = (k_depth > 2*array_n-1) ? k_depth : 2*array_n-1;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

  // Tile index width, never narrower than one bit.
  function automatic int tile_width(input int tile_num);
    return (tile_num > 1) ? $clog2(tile_num) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gemm_phase_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gemm_phase_cnt                                             |
// | Description : In-phase cycle counter. Counts up while enabled, saturates |
// |               at the supplied terminal value and clears on request.      |
// | Revision    : 1.0 - initial release                                      |
// | Ports       : clk, rst_n  - clock, async active-low reset                |
// |               en_i        - advance the count this cycle                 |
// |               clr_i       - return to zero (has priority over en_i)      |
// |               term_i      - terminal value of the current phase          |
// |               cnt_o       - current count                                |
// |               tc_o        - count equals terminal value                  |
// +--------------------------------------------------------------------------+
module gemm_phase_cnt
  import gemm_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [CW-1:0] term_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o  = (cnt_q == term_i);
  assign cnt_o = cnt_q;

  // Holding at the terminal value guarantees the counter never wraps even
  // if the owner is late to clear it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gemm_tile_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gemm_tile_sched                                            |
// | Description : Tile scheduler for an ARRAY_N x ARRAY_N systolic GEMM      |
// |               array. Per tile: LOAD weights (ARRAY_N cycles), FEED       |
// |               operands (K_DEPTH cycles), DRAIN results (2*ARRAY_N-1).    |
// |               After TILE_NUM tiles a one-cycle DONE pulse is emitted.    |
// | Revision    : 1.0 - initial release                                      |
// | Ports       : clk, rst_n  - clock, async active-low reset                |
// |               start_i     - job request, sampled only in IDLE            |
// |               stall_i     - operand buffer not ready (LOAD/FEED only)    |
// |               w_load_o    - weight-load strobe                           |
// |               feed_o      - operand-feed strobe                          |
// |               drain_o     - result-drain window                          |
// |               cnt_o       - in-phase cycle index / buffer address        |
// |               tile_o      - current tile index                           |
// |               busy_o      - not IDLE                                     |
// |               done_o      - one-cycle job-complete pulse                 |
// +--------------------------------------------------------------------------+
module gemm_tile_sched
  import gemm_pkg::*;
#(
  parameter int ARRAY_N  = 4,
  parameter int K_DEPTH  = 8,
  parameter int TILE_NUM = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start_i,
  input  logic                                     stall_i,
  output logic                                     w_load_o,
  output logic                                     feed_o,
  output logic                                     drain_o,
  output logic [cnt_width(ARRAY_N, K_DEPTH)-1:0]   cnt_o,
  output logic [tile_width(TILE_NUM)-1:0]          tile_o,
  output logic                                     busy_o,
  output logic                                     done_o
);

  localparam int CW = cnt_width(ARRAY_N, K_DEPTH);
  localparam int TW = tile_width(TILE_NUM);

  localparam logic [CW-1:0] LOAD_TERM  = CW'(ARRAY_N - 1);
  localparam logic [CW-1:0] FEED_TERM  = CW'(K_DEPTH - 1);
  localparam logic [CW-1:0] DRAIN_TERM = CW'(2*ARRAY_N - 2);
  localparam logic [TW-1:0] LAST_TILE  = TW'(TILE_NUM - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [CW-1:0] term;
  logic [CW-1:0] cnt;
  logic          advance;
  logic          cnt_clr;
  logic          tc;

  gemm_phase_cnt #(
    .CW (CW)
  ) u_phase_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (advance),
    .clr_i  (cnt_clr),
    .term_i (term),
    .cnt_o  (cnt),
    .tc_o   (tc)
  );

  // Next-state, tile counter and counter controls. start_i only matters in
  // IDLE; stall_i only matters in LOAD and FEED.
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    term    = '0;
    advance = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        tile_d  = '0;
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        term    = LOAD_TERM;
        advance = !stall_i;
        if (advance && tc) begin
          cnt_clr = 1'b1;
          state_d = FEED;
        end
      end
      FEED: begin
        term    = FEED_TERM;
        advance = !stall_i;
        if (advance && tc) begin
          cnt_clr = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        term    = DRAIN_TERM;
        advance = 1'b1;
        if (tc) begin
          cnt_clr = 1'b1;
          if (tile_q == LAST_TILE) begin
            // Tile index already reads zero during the DONE pulse.
            tile_d  = '0;
            state_d = DONE;
          end else begin
            tile_d  = tile_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        tile_d  = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        tile_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
    end
  end

  // Outputs decode registered state only; stall_i gates the two strobes.
  assign w_load_o = (state_q == LOAD) && !stall_i;
  assign feed_o   = (state_q == FEED) && !stall_i;
  assign drain_o  = (state_q == DRAIN);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign cnt_o    = cnt;
  assign tile_o   = tile_q;

endmodule
`default_nettype wire

// File: doc/gemm_tile_sched.md
GEMM_TILE_SCHED -- requirements
Module: gemm_tile_sched

Interface
REQ-001 The block SHALL have parameter ARRAY_N, default 4: systolic array dimension, in PEs per side.
REQ-002 The block SHALL have parameter K_DEPTH, default 8: operand feed cycles per tile.
REQ-003 The block SHALL have parameter TILE_NUM, default 2: number of tiles per job.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start_i, input, 1 bit: job request.
REQ-007 The block SHALL have port stall_i, input, 1 bit: operand buffer not ready; freezes progress in LOAD and FEED.
REQ-008 The block SHALL have port w_load_o, output, 1 bit: weight-load strobe to the array.
REQ-009 The block SHALL have port feed_o, output, 1 bit: operand-feed strobe to the array.
REQ-010 The block SHALL have port drain_o, output, 1 bit: result-drain window.
REQ-011 The block SHALL have port cnt_o, output, width CW = $clog2(max(K_DEPTH, 2*ARRAY_N-1)): in-phase cycle index, used as buffer address.
REQ-012 The block SHALL have port tile_o, output, width $clog2(TILE_NUM) with a minimum of 1: current tile index.
REQ-013 The block SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port done_o, output, 1 bit: one-cycle job-complete pulse.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, FEED, DRAIN and DONE, with a registered current state and a combinational next-state; unused encodings SHALL go to IDLE.
REQ-016 In IDLE, when start_i is sampled high, the FSM SHALL move to LOAD on the next edge with cnt_o=0 and tile_o=0; start_i SHALL be ignored in every other state.
REQ-017 The LOAD phase SHALL last ARRAY_N non-stalled cycles, with w_load_o = (state==LOAD) && !stall_i; when cnt_o==ARRAY_N-1 and there is no stall, the FSM SHALL go to FEED and clear cnt_o.
REQ-018 The FEED phase SHALL last K_DEPTH non-stalled cycles, with feed_o = (state==FEED) && !stall_i; when cnt_o==K_DEPTH-1 and there is no stall, the FSM SHALL go to DRAIN and clear cnt_o.
REQ-019 The DRAIN phase SHALL last exactly 2*ARRAY_N-1 cycles (systolic skew), with drain_o high throughout; stall_i SHALL be ignored in DRAIN.
REQ-020 At the end of DRAIN: if tile_o==TILE_NUM-1, the FSM SHALL go to DONE; otherwise tile_o SHALL increment and the FSM SHALL go to LOAD with cnt_o=0.
REQ-021 DONE SHALL last one cycle, with done_o=1, then go to IDLE; tile_o and cnt_o SHALL clear in DONE and IDLE.
REQ-022 While stall_i=1 in LOAD or FEED, cnt_o, tile_o and the state SHALL hold; a stall on the terminal count cycle SHALL delay the phase transition.
REQ-023 cnt_o SHALL increment by 1 per advancing cycle and SHALL never exceed its phase terminal value, so no wrap occurs.
REQ-024 With no stalls, job latency SHALL be TILE_NUM*(2*ARRAY_N-1+ARRAY_N+K_DEPTH) cycles from the start_i sample edge to DONE entry, plus 1.
REQ-025 All outputs SHALL be decoded from the registered state and counters only, with no combinational path from start_i; stall_i is the only input that reaches the strobes combinationally.

Reset
REQ-026 Asserting rst_n low at any time, including mid-job, SHALL immediately force state=IDLE, cnt_o=0 and tile_o=0, with all strobes, busy_o and done_o at 0.
REQ-027 After rst_n is released, the block SHALL wait in IDLE for a new start_i; no partial job SHALL resume.

Structure
REQ-028 The state encodings (3-bit localparams) and the CW width function SHALL live in the shared package gemm_pkg, which the array datapath blocks also use.
REQ-029 One sub-module, gemm_phase_cnt, SHALL be instantiated for the in-phase counter; it SHALL have enable, clear and terminal-value inputs and a terminal-count output. The tile counter SHALL be inline.

Verification
REQ-030 Nominal run (defaults, no stall): start_i pulsed at edge 0 -> LOAD cycles 1-4, FEED 5-12, DRAIN 13-19, tile 1 LOAD 20-23, FEED 24-31, DRAIN 32-38, done_o=1 at cycle 39 only.
REQ-031 Stall in FEED: stall_i=1 for 3 cycles while cnt_o=5 -> cnt_o holds at 5, feed_o=0 during the stall, and done_o is delayed to cycle 42.
REQ-032 Stall on the terminal count: stall_i=1 while LOAD cnt_o=3 -> the FSM stays in LOAD and enters FEED on the first unstalled cycle after it.
REQ-033 start_i held high for the whole job -> exactly one job runs, then a new job starts in the cycle after the return to IDLE; a start_i pulse mid-job is ignored.
REQ-034 Reset mid-operation: rst_n low during tile 1 FEED -> all outputs are 0 asynchronously, tile_o=0, and a following start_i produces a full nominal run.
REQ-035 Parameter sweep: ARRAY_N=2, K_DEPTH=3, TILE_NUM=1 -> done_o at cycle 9, and drain_o is high for 3 cycles.
